// File: rtl/receive_ps2_if.sv
// Byte-side bus of the PS/2 receiver: the accepted byte, its strobe, the
// error strobes and the busy flag, as seen by the keyboard/mouse decoder.
interface receive_ps2_if;
  logic [7:0] data;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  // Receiver side drives the bus.
  modport master (
    output data,
    output valid,
    output parity_err,
    output frame_err,
    output busy
  );

  // Decoder side consumes the bus.
  modport slave (
    input data,
    input valid,
    input parity_err,
    input frame_err,
    input busy
  );
endinterface

// File: rtl/receive_ps2.sv
// PS/2 device-to-host receiver. Synchronizes the psclk/psdata pins, detects
// psclk falling edges and deframes start / 8 data (LSB first) / odd parity /
// stop. Good bytes are presented with a one-cycle valid strobe; bad parity,
// bad stop bit and stalled frames produce one-cycle error strobes.
module receive_ps2 #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TO_WIDTH       = 10
) (
  input  logic          slowClk,
  input  logic          reset,
  input  logic          psclk,
  input  logic          psdata,
  input  logic          inhibit,
  receive_ps2_if.master rx
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  // Pin synchronizers: index 0 is psclk, index 1 is psdata.
  logic [1:0] pin_raw;
  logic [1:0] meta_reg;
  logic [1:0] sync_reg;
  logic       pastclk_reg;
  logic       clk_s;
  logic       data_s;
  logic       fall;

  // Frame state.
  state_t              state_reg, state_next;
  logic [2:0]          bitcnt_reg, bitcnt_next;
  logic [7:0]          shift_reg, shift_next;
  logic                par_reg, par_next;
  logic [TO_WIDTH-1:0] to_cnt_reg, to_cnt_next;
  logic [TO_WIDTH-1:0] to_inc;

  // Registered outputs.
  logic [7:0] data_reg, data_next;
  logic       valid_reg, valid_next;
  logic       perr_reg, perr_next;
  logic       ferr_reg, ferr_next;

  assign pin_raw = {psdata, psclk};

  // Two-flop synchronizer per pin; resets to the idle-high bus level.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge slowClk or posedge reset) begin
        if (reset) begin
          meta_reg[gi] <= 1'b1;
          sync_reg[gi] <= 1'b1;
        end else begin
          meta_reg[gi] <= pin_raw[gi];
          sync_reg[gi] <= meta_reg[gi];
        end
      end
    end
  endgenerate

  assign clk_s  = sync_reg[0];
  assign data_s = sync_reg[1];

  // Previous synchronized psclk; keeps running through inhibit so that
  // releasing inhibit never produces a stale edge.
  always_ff @(posedge slowClk or posedge reset) begin
    if (reset) pastclk_reg <= 1'b1;
    else       pastclk_reg <= clk_s;
  end

  assign fall   = pastclk_reg & ~clk_s;
  assign to_inc = to_cnt_reg + 1'b1;

  // State, counters, shift register and output registers.
  always_ff @(posedge slowClk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      bitcnt_reg <= '0;
      shift_reg  <= '0;
      par_reg    <= 1'b0;
      to_cnt_reg <= '0;
      data_reg   <= 8'h00;
      valid_reg  <= 1'b0;
      perr_reg   <= 1'b0;
      ferr_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      bitcnt_reg <= bitcnt_next;
      shift_reg  <= shift_next;
      par_reg    <= par_next;
      to_cnt_reg <= to_cnt_next;
      data_reg   <= data_next;
      valid_reg  <= valid_next;
      perr_reg   <= perr_next;
      ferr_reg   <= ferr_next;
    end
  end

  // Next-state and strobe logic. Priority: inhibit, then a psclk fall, then
  // the inter-edge timeout (a fall on the terminal count wins).
  always_comb begin
    state_next  = state_reg;
    bitcnt_next = bitcnt_reg;
    shift_next  = shift_reg;
    par_next    = par_reg;
    to_cnt_next = to_cnt_reg;
    data_next   = data_reg;
    valid_next  = 1'b0;
    perr_next   = 1'b0;
    ferr_next   = 1'b0;

    if (inhibit) begin
      state_next  = IDLE;
      bitcnt_next = '0;
      to_cnt_next = '0;
    end else if (fall) begin
      to_cnt_next = '0;
      case (state_reg)
        IDLE: begin
          // A high data line at a falling edge is not a start bit: ignore it.
          if (!data_s) begin
            state_next  = DATA;
            bitcnt_next = '0;
          end
        end
        DATA: begin
          shift_next  = {data_s, shift_reg[7:1]};
          bitcnt_next = bitcnt_reg + 3'd1;
          if (bitcnt_reg == 3'd7) state_next = PARITY;
        end
        PARITY: begin
          par_next   = data_s;
          state_next = STOP;
        end
        STOP: begin
          state_next  = IDLE;
          bitcnt_next = '0;
          // A bad stop bit outranks a parity error.
          if (!data_s) begin
            ferr_next = 1'b1;
          end else if (^{shift_reg, par_reg}) begin
            data_next  = shift_reg;
            valid_next = 1'b1;
          end else begin
            perr_next = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end else if (state_reg == IDLE) begin
      to_cnt_next = '0;
    end else if (to_inc == TO_LAST) begin
      // Sender stalled mid-frame: drop the partial frame.
      state_next  = IDLE;
      bitcnt_next = '0;
      to_cnt_next = '0;
      ferr_next   = 1'b1;
    end else begin
      to_cnt_next = to_inc;
    end
  end

  assign rx.data       = data_reg;
  assign rx.valid      = valid_reg;
  assign rx.parity_err = perr_reg;
  assign rx.frame_err  = ferr_reg;
  assign rx.busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_receive_ps2.sv
// Directed bench for receive_ps2: sends PS/2 frames bit by bit on psclk/psdata
// and checks the byte bus, strobe counts and the inter-edge timeout.
`timescale 1ns/1ps
module tb_receive_ps2;
  logic slowClk = 1'b0;
  logic reset;
  logic psclk;
  logic psdata;
  logic inhibit;

  receive_ps2_if rx ();

  receive_ps2 #(.TIMEOUT_CYCLES(1000), .TO_WIDTH(10)) dut (
    .slowClk (slowClk),
    .reset   (reset),
    .psclk   (psclk),
    .psdata  (psdata),
    .inhibit (inhibit),
    .rx      (rx)
  );

  always #5 slowClk = ~slowClk;

  int checks = 0;
  int errors = 0;

  // Strobe monitors: rising-edge counts and high-cycle counts.
  int   valid_rise = 0, valid_hi = 0;
  int   perr_rise  = 0, perr_hi  = 0;
  int   ferr_rise  = 0, ferr_hi  = 0;
  logic valid_prev = 1'b0, perr_prev = 1'b0, ferr_prev = 1'b0;

  always @(negedge slowClk) begin
    if (rx.valid) valid_hi <= valid_hi + 1;
    if (rx.valid && !valid_prev) valid_rise <= valid_rise + 1;
    if (rx.parity_err) perr_hi <= perr_hi + 1;
    if (rx.parity_err && !perr_prev) perr_rise <= perr_rise + 1;
    if (rx.frame_err) ferr_hi <= ferr_hi + 1;
    if (rx.frame_err && !ferr_prev) ferr_rise <= ferr_rise + 1;
    valid_prev <= rx.valid;
    perr_prev  <= rx.parity_err;
    ferr_prev  <= rx.frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-18s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Frame vector: bit 0 start, bits 8:1 data LSB first, bit 9 parity, bit 10 stop.
  function automatic logic [10:0] frame(input logic [7:0] d, input logic par, input logic stop);
    return {stop, par, d, 1'b0};
  endfunction

  // Send bits first..last: data set while psclk high, 40-cycle low phase.
  task automatic send_bits(input logic [10:0] bits, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      psdata = bits[i];
      repeat (20) @(negedge slowClk);
      psclk = 1'b0;
      repeat (40) @(negedge slowClk);
      psclk = 1'b1;
      repeat (20) @(negedge slowClk);
    end
    psdata = 1'b1;
  endtask

  int v0, p0, f0, n;
  logic [10:0] fr;

  initial begin
    reset = 1'b1; psclk = 1'b1; psdata = 1'b1; inhibit = 1'b0;
    repeat (3) @(negedge slowClk);
    check("rst_data",  32'(rx.data), 32'h00);
    check("rst_valid", 32'(rx.valid), 32'h0);
    check("rst_perr",  32'(rx.parity_err), 32'h0);
    check("rst_ferr",  32'(rx.frame_err), 32'h0);
    check("rst_busy",  32'(rx.busy), 32'h0);
    reset = 1'b0;
    repeat (10) @(negedge slowClk);

    // Good frame 0x1C, busy across the frame.
    v0 = valid_rise; p0 = perr_rise; f0 = ferr_rise;
    fr = frame(8'h1C, 1'b0, 1'b1);
    send_bits(fr, 0, 0);
    check("1c_busy_start", 32'(rx.busy), 32'h1);
    send_bits(fr, 1, 9);
    check("1c_busy_parity", 32'(rx.busy), 32'h1);
    send_bits(fr, 10, 10);
    check("1c_busy_end", 32'(rx.busy), 32'h0);
    check("1c_valid", 32'(valid_rise - v0), 32'd1);
    check("1c_data", 32'(rx.data), 32'h1C);
    check("1c_noerr", 32'((perr_rise - p0) + (ferr_rise - f0)), 32'd0);

    // Back-to-back 0xF0 then 0x1C.
    v0 = valid_rise;
    send_bits(frame(8'hF0, 1'b1, 1'b1), 0, 10);
    check("f0_data", 32'(rx.data), 32'hF0);
    send_bits(frame(8'h1C, 1'b0, 1'b1), 0, 10);
    check("b2b_data", 32'(rx.data), 32'h1C);
    check("b2b_valid", 32'(valid_rise - v0), 32'd2);

    // Parity error on 0x1C.
    v0 = valid_rise; p0 = perr_rise; f0 = ferr_rise;
    send_bits(frame(8'h1C, 1'b1, 1'b1), 0, 10);
    check("perr_pulse", 32'(perr_rise - p0), 32'd1);
    check("perr_novalid", 32'(valid_rise - v0), 32'd0);
    check("perr_data", 32'(rx.data), 32'h1C);

    // Bad stop bit on 0xAA.
    v0 = valid_rise; p0 = perr_rise; f0 = ferr_rise;
    send_bits(frame(8'hAA, 1'b1, 1'b0), 0, 10);
    check("stop_ferr", 32'(ferr_rise - f0), 32'd1);
    check("stop_noother", 32'((valid_rise - v0) + (perr_rise - p0)), 32'd0);
    check("stop_data", 32'(rx.data), 32'h1C);

    // Timeout: start + 5 data bits, then psclk stays high. The last fall is
    // acted on at the 3rd rising edge after psclk drops; frame_err follows
    // 999 edges later, i.e. at edge 1002.
    f0 = ferr_rise;
    fr = frame(8'hAA, 1'b1, 1'b1);
    send_bits(fr, 0, 4);
    psdata = fr[5];
    repeat (20) @(negedge slowClk);
    psclk = 1'b0;
    n = 0;
    for (int k = 1; k <= 1200; k++) begin
      @(negedge slowClk);
      if (k == 40) psclk = 1'b1;
      if (rx.frame_err && n == 0) n = k;
    end
    psdata = 1'b1;
    check("to_latency", 32'(n), 32'd1002);
    check("to_busy", 32'(rx.busy), 32'h0);
    check("to_ferr", 32'(ferr_rise - f0), 32'd1);
    v0 = valid_rise;
    send_bits(frame(8'hAA, 1'b1, 1'b1), 0, 10);
    check("to_next_valid", 32'(valid_rise - v0), 32'd1);
    check("to_next_data", 32'(rx.data), 32'hAA);

    // Inhibit after 4 data bits, with psclk activity while inhibited.
    v0 = valid_rise; p0 = perr_rise; f0 = ferr_rise;
    fr = frame(8'h55, 1'b1, 1'b1);
    send_bits(fr, 0, 4);
    inhibit = 1'b1;
    send_bits(fr, 5, 7);
    repeat (1100) @(negedge slowClk);
    check("inh_busy", 32'(rx.busy), 32'h0);
    check("inh_nopulse", 32'((valid_rise - v0) + (perr_rise - p0) + (ferr_rise - f0)), 32'd0);
    inhibit = 1'b0;
    repeat (10) @(negedge slowClk);
    send_bits(fr, 0, 10);
    check("inh_valid", 32'(valid_rise - v0), 32'd1);
    check("inh_data", 32'(rx.data), 32'h55);
    check("inh_noerr", 32'((perr_rise - p0) + (ferr_rise - f0)), 32'd0);

    // Reset mid-frame.
    v0 = valid_rise; p0 = perr_rise; f0 = ferr_rise;
    send_bits(frame(8'hF0, 1'b1, 1'b1), 0, 4);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_data", 32'(rx.data), 32'h00);
    check("mid_rst_busy", 32'(rx.busy), 32'h0);
    repeat (3) @(negedge slowClk);
    reset = 1'b0;
    repeat (10) @(negedge slowClk);
    check("mid_rst_nopulse", 32'((valid_rise - v0) + (perr_rise - p0) + (ferr_rise - f0)), 32'd0);
    send_bits(frame(8'h1C, 1'b0, 1'b1), 0, 10);
    check("mid_rst_valid", 32'(valid_rise - v0), 32'd1);
    check("mid_rst_data2", 32'(rx.data), 32'h1C);

    // Every strobe lasted exactly one cycle.
    check("valid_width", 32'(valid_hi), 32'(valid_rise));
    check("perr_width", 32'(perr_hi), 32'(perr_rise));
    check("ferr_width", 32'(ferr_hi), 32'(ferr_rise));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
